// File: rtl/simd_mac_fu.sv
// Two-stage SIMD multiply-accumulate unit: S1 forms signed x unsigned lane products,
// S2 reduces them and updates one of NUM_ACC accumulators, registering the result.
module simd_mac_fu #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ELEM_W        = 8,
    parameter int unsigned NUM_ACC       = 4,
    parameter int unsigned TRANS_ID_BITS = 3,
    localparam int unsigned SEL_W        = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    input  logic [2:0]               op_i,
    input  logic                     sat_i,
    input  logic [SEL_W-1:0]         acc_sel_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam logic [2:0] OP_INIT = 3'd0;
    localparam logic [2:0] OP_ACC  = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;

    localparam int LANES  = int'(XLEN / ELEM_W);
    localparam int PROD_W = int'(2 * ELEM_W + 1);
    // Wide enough to hold the exact sum of all lane products before truncation.
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    localparam int EXT_W  = (SUM_W > int'(XLEN)) ? SUM_W : int'(XLEN);

    logic accept;

    logic signed [PROD_W-1:0] prod [LANES];

    logic                     s1_valid;
    logic [2:0]               s1_op;
    logic                     s1_sat;
    logic [SEL_W-1:0]         s1_sel;
    logic [XLEN-1:0]          s1_opa;
    logic [TRANS_ID_BITS-1:0] s1_id;
    logic signed [PROD_W-1:0] s1_prod [LANES];

    logic [XLEN-1:0]          acc [NUM_ACC];

    logic signed [EXT_W-1:0]  sum_ext;
    logic [XLEN-1:0]          sum;
    logic [XLEN-1:0]          acc_cur;
    logic [XLEN:0]            add_ext;
    logic                     add_ovf;
    logic [XLEN-1:0]          acc_sum;
    logic [XLEN-1:0]          new_val;
    logic                     acc_we;
    logic                     commit;

    assign ready_o = ~rst_i;
    assign accept  = valid_i & ready_o & ~flush_i;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = $signed({{(ELEM_W + 1){operand_a_i[i*ELEM_W + ELEM_W - 1]}},
                               operand_a_i[i*ELEM_W +: ELEM_W]})
                    * $signed({{(ELEM_W + 1){1'b0}}, operand_b_i[i*ELEM_W +: ELEM_W]});
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_INIT;
            s1_sat   <= 1'b0;
            s1_sel   <= '0;
            s1_opa   <= '0;
            s1_id    <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= op_i;
                s1_sat <= sat_i;
                s1_sel <= acc_sel_i;
                s1_opa <= operand_a_i;
                s1_id  <= trans_id_i;
                for (int i = 0; i < LANES; i++) begin
                    s1_prod[i] <= prod[i];
                end
            end
        end
    end

    always_comb begin
        sum_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_ext = sum_ext + {{(EXT_W - PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]};
        end
        sum = sum_ext[XLEN-1:0];
    end

    // The accumulator is read combinationally in S2, so a write at the end of one cycle is
    // already seen by the operation entering S2 in the next cycle.
    always_comb begin
        acc_cur = acc[s1_sel];
        add_ext = {acc_cur[XLEN-1], acc_cur} + {sum[XLEN-1], sum};
        add_ovf = add_ext[XLEN] ^ add_ext[XLEN-1];
        if (s1_sat && add_ovf) begin
            acc_sum = add_ext[XLEN] ? {1'b1, {(XLEN - 1){1'b0}}} : {1'b0, {(XLEN - 1){1'b1}}};
        end else begin
            acc_sum = add_ext[XLEN-1:0];
        end
    end

    always_comb begin
        new_val = acc_cur;
        acc_we  = 1'b0;
        case (s1_op)
            OP_INIT: begin
                new_val = sum;
                acc_we  = 1'b1;
            end
            OP_ACC: begin
                new_val = acc_sum;
                acc_we  = 1'b1;
            end
            OP_CLR: begin
                new_val = '0;
                acc_we  = 1'b1;
            end
            OP_LOAD: begin
                new_val = s1_opa;
                acc_we  = 1'b1;
            end
            default: begin
                new_val = acc_cur;
                acc_we  = 1'b0;
            end
        endcase
    end

    // A flush kills the S1 operation before it can touch an accumulator.
    assign commit = s1_valid & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
            for (int i = 0; i < int'(NUM_ACC); i++) begin
                acc[i] <= '0;
            end
        end else begin
            valid_o <= commit;
            if (commit) begin
                result_o   <= new_val;
                trans_id_o <= s1_id;
                if (acc_we) begin
                    acc[s1_sel] <= new_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_mac_fu.sv
// Randomized plus directed bench for simd_mac_fu, checked against a transaction-level
// integer model of the accumulators.
module tb_simd_mac_fu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [2:0]  op_i;
    logic        sat_i;
    logic [1:0]  acc_sel_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [2:0]  trans_id_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic [2:0]  trans_id_o;

    simd_mac_fu #(
        .XLEN         (32),
        .ELEM_W       (8),
        .NUM_ACC      (4),
        .TRANS_ID_BITS(3)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .flush_i    (flush_i),
        .op_i       (op_i),
        .sat_i      (sat_i),
        .acc_sel_i  (acc_sel_i),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .trans_id_i (trans_id_i),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .trans_id_o (trans_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        sat;
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  id;
    } op_t;

    int n_tests = 0;
    int n_fail  = 0;

    longint macc [4];
    logic   pend_v;
    op_t    pend;
    logic        exp_valid;
    logic [31:0] exp_res;
    logic [2:0]  exp_id;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint mac_sum(input logic [31:0] a, input logic [31:0] b);
        longint s;
        int     sa;
        int     ub;
        logic [7:0] ab;
        logic [7:0] bb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ab = a[i*8 +: 8];
            bb = b[i*8 +: 8];
            sa = $signed(ab);
            ub = int'({24'b0, bb});
            s  = s + longint'(sa) * longint'(ub);
        end
        return s;
    endfunction

    function automatic logic [31:0] model_apply(input op_t o);
        longint s;
        longint t;
        int     w;
        s = mac_sum(o.a, o.b);
        case (o.op)
            3'd0: begin
                macc[o.sel] = s;
            end
            3'd1: begin
                t = macc[o.sel] + s;
                if (o.sat) begin
                    if (t > 64'sd2147483647) t = 64'sd2147483647;
                    if (t < -64'sd2147483648) t = -64'sd2147483648;
                end else begin
                    w = int'(t);
                    t = longint'(w);
                end
                macc[o.sel] = t;
            end
            3'd3: macc[o.sel] = 0;
            3'd4: begin
                w = $signed(o.a);
                macc[o.sel] = longint'(w);
            end
            default: ;
        endcase
        t = macc[o.sel];
        return t[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) macc[i] = 0;
        pend_v    = 1'b0;
        exp_valid = 1'b0;
        exp_res   = '0;
        exp_id    = '0;
    endtask

    // One clock cycle: check this cycle's outputs, drive new inputs, advance the model.
    task automatic cycle(input logic v, input op_t o, input logic fl);
        @(negedge clk);
        check("ready", 64'(ready_o), 64'(1'b1));
        check("valid", 64'(valid_o), 64'(exp_valid));
        check("result", 64'(result_o), 64'(exp_res));
        check("tid", 64'(trans_id_o), 64'(exp_id));
        valid_i     = v;
        flush_i     = fl;
        op_i        = o.op;
        sat_i       = o.sat;
        acc_sel_i   = o.sel;
        operand_a_i = o.a;
        operand_b_i = o.b;
        trans_id_i  = o.id;
        if (fl || !pend_v) begin
            exp_valid = 1'b0;
        end else begin
            exp_res   = model_apply(pend);
            exp_id    = pend.id;
            exp_valid = 1'b1;
        end
        pend_v = v && !fl;
        pend   = o;
    endtask

    function automatic op_t mk(input logic [2:0] op, input logic sat, input logic [1:0] sel,
                               input logic [31:0] a, input logic [31:0] b, input logic [2:0] id);
        op_t o;
        o.op = op; o.sat = sat; o.sel = sel; o.a = a; o.b = b; o.id = id;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.op  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        o.sat = 1'($urandom_range(0, 1));
        o.sel = 2'($urandom_range(0, 3));
        o.a   = $urandom;
        o.b   = $urandom;
        o.id  = 3'($urandom_range(0, 7));
        if (o.op == 3'd4 && $urandom_range(0, 1) == 1) begin
            o.a = ($urandom_range(0, 1) == 1) ? (32'h7FFF0000 | 32'($urandom_range(0, 65535)))
                                              : (32'h80000000 | 32'($urandom_range(0, 65535)));
        end
        return o;
    endfunction

    op_t idle;
    op_t o;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle = mk(3'd2, 1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
        model_reset();
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = '0; sat_i = 1'b0;
        acc_sel_i = '0; operand_a_i = '0; operand_b_i = '0; trans_id_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'(1'b0));
        check("rst_valid", 64'(valid_o), 64'(1'b0));
        check("rst_result", 64'(result_o), 64'h0);
        check("rst_tid", 64'(trans_id_o), 64'h0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Basic dot product then back-to-back accumulation on acc0.
        cycle(1'b1, mk(3'd0, 1'b0, 2'd0, 32'hFF010203, 32'h04030201, 3'd1), 1'b0);
        cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 32'hFF010203, 32'h04030201, 3'd2), 1'b0);
        cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 32'hFF010203, 32'h04030201, 3'd3), 1'b0);
        check("init_6", 64'(result_o), 64'h6);
        cycle(1'b0, idle, 1'b0);
        check("acc_c", 64'(result_o), 64'hC);
        cycle(1'b0, idle, 1'b0);
        check("acc_12", 64'(result_o), 64'h12);

        // Saturating vs wrapping accumulate near the positive limit.
        cycle(1'b1, mk(3'd4, 1'b0, 2'd1, 32'h7FFFFFF0, 32'h0, 3'd4), 1'b0);
        cycle(1'b1, mk(3'd1, 1'b1, 2'd1, 32'h7F7F7F7F, 32'hFFFFFFFF, 3'd5), 1'b0);
        cycle(1'b1, mk(3'd4, 1'b0, 2'd1, 32'h7FFFFFF0, 32'h0, 3'd6), 1'b0);
        cycle(1'b1, mk(3'd1, 1'b0, 2'd1, 32'h7F7F7F7F, 32'hFFFFFFFF, 3'd7), 1'b0);
        check("sat_max", 64'(result_o), 64'h7FFFFFFF);
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);
        check("wrap", 64'(result_o), 64'h8001F9F4);

        // Flushed INIT must leave acc2 untouched.
        cycle(1'b1, mk(3'd4, 1'b0, 2'd2, 32'h12345678, 32'h0, 3'd1), 1'b0);
        cycle(1'b1, mk(3'd0, 1'b0, 2'd2, 32'hFF010203, 32'h04030201, 3'd2), 1'b0);
        cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 32'h01010101, 32'h01010101, 3'd3), 1'b1);
        cycle(1'b1, mk(3'd2, 1'b0, 2'd2, 32'h0, 32'h0, 3'd4), 1'b0);
        check("flush_novalid", 64'(valid_o), 64'(1'b0));
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);
        check("flush_read", 64'(result_o), 64'h12345678);

        // Interleaved accumulators with distinct tags.
        cycle(1'b1, mk(3'd0, 1'b0, 2'd0, $urandom, $urandom, 3'd1), 1'b0);
        cycle(1'b1, mk(3'd0, 1'b0, 2'd3, $urandom, $urandom, 3'd2), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, mk(3'd1, 1'b0, (i % 2 == 0) ? 2'd0 : 2'd3, $urandom, $urandom,
                           3'(i + 3)), 1'b0);
        end
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);

        // Reset while two operations are in flight.
        cycle(1'b1, mk(3'd4, 1'b0, 2'd3, 32'hDEADBEEF, 32'h0, 3'd5), 1'b0);
        cycle(1'b1, mk(3'd4, 1'b0, 2'd0, 32'hCAFEF00D, 32'h0, 3'd6), 1'b0);
        cycle(1'b0, idle, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(valid_o), 64'(1'b0));
        check("arst_ready", 64'(ready_o), 64'(1'b0));
        check("arst_result", 64'(result_o), 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, mk(3'd2, 1'b0, 2'(i), 32'h0, 32'h0, 3'(i)), 1'b0);
        end
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);

        // Random traffic with occasional flushes and bubbles.
        for (int n = 0; n < 1500; n++) begin
            o = rnd_op();
            cycle(($urandom_range(0, 7) != 0), o, ($urandom_range(0, 15) == 0));
        end
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_mac_fu.md
SIMD_MAC_FU -- requirements
Module: simd_mac_fu

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 Parameter ELEM_W, default 8, lane width; legal values are 8 and 16, dividing XLEN; lane count L = XLEN/ELEM_W.
REQ-003 Parameter NUM_ACC, default 4, number of accumulators, each XLEN wide; power of 2, at least 1.
REQ-004 Parameter TRANS_ID_BITS, default 3, transaction ID width.
REQ-005 clk_i input 1: single clock; all state on the rising edge.
REQ-006 rst_i input 1: asynchronous, active-high reset.
REQ-007 valid_i input 1: operation offered.
REQ-008 ready_o output 1: unit accepts an operation this cycle.
REQ-009 flush_i input 1: kill all in-flight operations.
REQ-010 op_i input 3: 0 INIT, 1 ACC, 2 READ, 3 CLR, 4 LOAD; codes 5-7 are treated as READ.
REQ-011 sat_i input 1: saturating accumulate, used by ACC only.
REQ-012 acc_sel_i input clog2(NUM_ACC) (at least 1): accumulator index.
REQ-013 operand_a_i input XLEN: signed lanes.
REQ-014 operand_b_i input XLEN: unsigned lanes.
REQ-015 trans_id_i input TRANS_ID_BITS: transaction tag.
REQ-016 result_o output XLEN: registered result.
REQ-017 valid_o output 1: result_o is valid; no output backpressure.
REQ-018 trans_id_o output TRANS_ID_BITS: tag of the result.

Function
REQ-019 The unit SHALL accept an operation when valid_i && ready_o && !flush_i.
REQ-020 ready_o SHALL be 1 whenever rst_i is low and 0 while rst_i is high.
REQ-021 The unit SHALL be a 2-stage pipeline: S1 registers the lane products, op, sel, sat and tag; S2 reduces, updates the accumulator and registers the result.
REQ-022 An operation accepted in cycle N SHALL assert valid_o in cycle N+2; the unit SHALL sustain one operation per cycle.
REQ-023 Lane i product SHALL be signed(a[i]) x unsigned(b[i]), computed exactly in 2*ELEM_W+1 bits.
REQ-024 sum SHALL be the exact signed sum of the L products, sign-extended to XLEN.
REQ-025 INIT SHALL set acc[sel] = sum; result = sum.
REQ-026 ACC SHALL set acc[sel] = acc[sel] + sum; result = the new value.
REQ-027 With sat_i=0, ACC SHALL wrap modulo 2^XLEN.
REQ-028 With sat_i=1, ACC SHALL clamp to [-2^(XLEN-1), 2^(XLEN-1)-1].
REQ-029 READ SHALL return acc[sel] and leave all accumulators unchanged.
REQ-030 CLR SHALL set acc[sel] = 0; result = 0.
REQ-031 LOAD SHALL set acc[sel] = operand_a_i; result = operand_a_i.
REQ-032 The S2 update SHALL be visible to the next operation entering S2 in the following cycle, so back-to-back operations on the same accumulator see the updated value with no stall.
REQ-033 Operations on different accumulators SHALL NOT affect each other.
REQ-034 flush_i high in cycle F SHALL invalidate S1 and S2 contents at the end of cycle F; neither operation updates any accumulator, and valid_o SHALL be 0 in cycle F+1.
REQ-035 flush_i SHALL NOT clear the accumulators.
REQ-036 valid_i together with flush_i SHALL NOT be accepted.
REQ-037 trans_id_o SHALL equal the trans_id_i of the operation whose result is on result_o.
REQ-038 When valid_o is 0, result_o and trans_id_o hold their previous values.

Reset
REQ-039 While rst_i is high, all accumulators SHALL be 0, both pipeline valid bits 0, valid_o 0, result_o 0, trans_id_o 0 and ready_o 0.
REQ-040 Reset asserted mid-operation SHALL discard in-flight operations immediately (asynchronously).
REQ-041 The first operation SHALL be accepted in the first cycle after rst_i falls.

Verification (ELEM_W=8, XLEN=32, NUM_ACC=4)
REQ-042 INIT sel0, a=0xFF010203, b=0x04030201 at cycle N -> valid_o at N+2, result_o=0x00000006.
REQ-043 Back-to-back ACC sel0 with the same operands in cycles N+1 and N+2 -> results 0x0000000C at N+3 and 0x00000012 at N+4.
REQ-044 LOAD sel1 0x7FFFFFF0, then ACC a=0x7F7F7F7F, b=0xFFFFFFFF -> 0x7FFFFFFF with sat_i=1; 0x8001F9F4 with sat_i=0.
REQ-045 INIT sel2 (sum 6) accepted, then flush_i in the next cycle -> no valid_o; READ sel2 returns the prior value of acc[2].
REQ-046 Interleaved ACC on sel0 and sel3 with distinct tags -> each accumulator evolves independently; trans_id_o matches each result in order.
REQ-047 rst_i asserted while two operations are in flight -> valid_o drops immediately; READ of every accumulator after reset returns 0.
